fir_axilite_slave: RTL and testbench

AXI-Lite responder and control-register block for the FIR engine. It accepts the configuration writes and read-backs a bus master issues: ap_ctrl, data_length, tap_num and the coefficient window. It owns the tap BRAM port, handing the port to the FIR datapath while a run is active. It sits between the AXI-Lite bus and the FIR datapath/tap_RAM (bram32, 1-cycle registered read).

---
 rtl/fir_axilite_slave.sv | 210 +++++++++++++++++++++
 tb/tb_fir_axilite_slave.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_axilite_slave.sv
// Purpose : AXI-Lite control/coefficient slave for the FIR engine; owns the tap BRAM port while idle.
// Latency : a write commits one cycle after AW and W are both held; rvalid rises 3 cycles after AR.
// Backpr. : awready/wready stay low while their holding reg is full; rvalid/rdata hold until rready.
module fir_axilite_slave #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic                   ap_start,
  input  logic                   ap_done_in,
  input  logic                   core_tap_EN,
  input  logic [pADDR_WIDTH-1:0] core_tap_A,
  output logic [31:0]            data_length,
  output logic [31:0]            tap_num
);

  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'(32'h00);
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(32'h10);
  localparam logic [pADDR_WIDTH-1:0] ADDR_TAPS = pADDR_WIDTH'(32'h14);
  localparam logic [pADDR_WIDTH-1:0] TAP_LO    = pADDR_WIDTH'(32'h80);
  localparam logic [pADDR_WIDTH-1:0] TAP_HI    = pADDR_WIDTH'(32'hFF);

  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DATA, R_VALID} r_state_t;

  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a >= TAP_LO) && (a <= TAP_HI);
  endfunction

  // Write holding registers and control state
  logic                   aw_full;
  logic                   w_full;
  logic [pADDR_WIDTH-1:0] aw_addr_q;
  logic [pDATA_WIDTH-1:0] w_data_q;
  logic                   idle;
  logic                   done;

  // Commit strobes, all qualified by idle except the plain "ignored" cases
  logic commit;
  logic wr_start;
  logic wr_len;
  logic wr_taps;
  logic wr_coef;

  // Read side
  r_state_t               r_state;
  r_state_t               r_state_nxt;
  logic [pADDR_WIDTH-1:0] ar_addr_q;
  logic                   tap_rd_q;      // tap read really went to the BRAM for this access
  logic                   rd_tap_issue;
  logic                   rd_ctrl_ack;
  logic [pDATA_WIDTH-1:0] rd_val;

  assign awready = ~aw_full;
  assign wready  = ~w_full;
  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_VALID);

  assign commit   = aw_full & w_full;
  assign wr_start = commit & idle & (aw_addr_q == ADDR_CTRL) & w_data_q[0];
  assign wr_len   = commit & idle & (aw_addr_q == ADDR_LEN);
  assign wr_taps  = commit & idle & (aw_addr_q == ADDR_TAPS);
  assign wr_coef  = commit & idle & is_tap(aw_addr_q);

  assign rd_ctrl_ack = (r_state == R_VALID) & rready & (ar_addr_q == ADDR_CTRL);

  // Capture AW and W independently; both flags drop together after the commit cycle.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
    end else if (commit) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        aw_full   <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (wvalid && wready) begin
        w_full   <= 1'b1;
        w_data_q <= wdata;
      end
    end
  end

  // Control registers; a completion pulse overrides a same-cycle done clear.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      ap_start    <= 1'b0;
      idle        <= 1'b1;
      done        <= 1'b0;
      data_length <= '0;
      tap_num     <= '0;
    end else begin
      ap_start <= wr_start;
      if (wr_len)  data_length <= 32'(w_data_q);
      if (wr_taps) tap_num     <= 32'(w_data_q);
      if (wr_start) begin
        idle <= 1'b0;
        done <= 1'b0;
      end else if (rd_ctrl_ack) begin
        done <= 1'b0;
      end
      if (ap_done_in) begin
        done <= 1'b1;
        idle <= 1'b1;
      end
    end
  end

  // Read FSM next state; a tap read yields the BRAM port to a same-cycle write commit.
  always_comb begin
    r_state_nxt  = r_state;
    rd_tap_issue = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        if (arvalid) r_state_nxt = R_ISSUE;
      end
      R_ISSUE: begin
        if (is_tap(ar_addr_q) && idle) begin
          if (!commit) begin
            rd_tap_issue = 1'b1;
            r_state_nxt  = R_DATA;
          end
        end else begin
          r_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        r_state_nxt = R_VALID;
      end
      R_VALID: begin
        if (rready) r_state_nxt = R_IDLE;
      end
      default: begin
        r_state_nxt = R_IDLE;
      end
    endcase
  end

  // Read-data select: tap window returns all-ones when the BRAM port belonged to the core.
  always_comb begin
    rd_val = '0;
    if (is_tap(ar_addr_q)) begin
      rd_val = tap_rd_q ? tap_Do : '1;
    end else if (ar_addr_q == ADDR_CTRL) begin
      rd_val = pDATA_WIDTH'({idle, done, ap_start});
    end else if (ar_addr_q == ADDR_LEN) begin
      rd_val = pDATA_WIDTH'(data_length);
    end else if (ar_addr_q == ADDR_TAPS) begin
      rd_val = pDATA_WIDTH'(tap_num);
    end
  end

  // Read FSM state, latched address and captured read data.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_state   <= R_IDLE;
      ar_addr_q <= '0;
      tap_rd_q  <= 1'b0;
      rdata     <= '0;
    end else begin
      r_state <= r_state_nxt;
      if ((r_state == R_IDLE) && arvalid) ar_addr_q <= araddr;
      if (r_state == R_ISSUE)             tap_rd_q  <= rd_tap_issue;
      if (r_state == R_DATA)              rdata     <= rd_val;
    end
  end

  // Tap BRAM port mux: core while busy, otherwise write commit first, then read issue.
  always_comb begin
    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_A  = '0;
    tap_Di = '0;
    if (!idle) begin
      tap_EN = core_tap_EN;
      tap_A  = core_tap_A;
    end else if (wr_coef) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = aw_addr_q - TAP_LO;
      tap_Di = w_data_q;
    end else if (rd_tap_issue) begin
      tap_EN = 1'b1;
      tap_A  = ar_addr_q - TAP_LO;
    end
  end

endmodule

// File: tb/tb_fir_axilite_slave.sv
// Purpose : directed bench for fir_axilite_slave with a 1-cycle registered-read tap BRAM model.
// Latency : all stimulus is driven and sampled on the falling edge of axis_clk.
// Backpr. : waits on ready/valid are bounded; an expired bound shows up as a failed check.
module tb_fir_axilite_slave;

  logic        axis_clk = 1'b0;
  logic        axis_rst;
  logic        awvalid, awready;
  logic [11:0] awaddr;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic        arvalid, arready;
  logic [11:0] araddr;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [3:0]  tap_WE;
  logic        tap_EN;
  logic [31:0] tap_Di;
  logic [11:0] tap_A;
  logic [31:0] tap_Do;
  logic        ap_start;
  logic        ap_done_in;
  logic        core_tap_EN;
  logic [11:0] core_tap_A;
  logic [31:0] data_length;
  logic [31:0] tap_num;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] tap_mem [0:63];

  always #5 axis_clk = ~axis_clk;

  fir_axilite_slave #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) dut (
    .axis_clk    (axis_clk),
    .axis_rst    (axis_rst),
    .awvalid     (awvalid),
    .awready     (awready),
    .awaddr      (awaddr),
    .wvalid      (wvalid),
    .wready      (wready),
    .wdata       (wdata),
    .arvalid     (arvalid),
    .arready     (arready),
    .araddr      (araddr),
    .rvalid      (rvalid),
    .rready      (rready),
    .rdata       (rdata),
    .tap_WE      (tap_WE),
    .tap_EN      (tap_EN),
    .tap_Di      (tap_Di),
    .tap_A       (tap_A),
    .tap_Do      (tap_Do),
    .ap_start    (ap_start),
    .ap_done_in  (ap_done_in),
    .core_tap_EN (core_tap_EN),
    .core_tap_A  (core_tap_A),
    .data_length (data_length),
    .tap_num     (tap_num)
  );

  // Tap BRAM model: byte-enabled write, read-first registered read.
  always @(posedge axis_clk) begin
    if (tap_EN) begin
      for (int b = 0; b < 4; b++)
        if (tap_WE[b]) tap_mem[tap_A[7:2]][8*b +: 8] <= tap_Di[8*b +: 8];
      tap_Do <= tap_mem[tap_A[7:2]];
    end
  end

  // Watchdog against a hung handshake
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d assertions, %0d failures", n_assert, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge axis_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_aw(input logic [11:0] a);
    int n = 0;
    awaddr = a; awvalid = 1'b1;
    while (!awready && n < 16) begin step(); n++; end
    chk("awready_wait", 32'(awready), 32'd1);
    step();
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d);
    int n = 0;
    wdata = d; wvalid = 1'b1;
    while (!wready && n < 16) begin step(); n++; end
    chk("wready_wait", 32'(wready), 32'd1);
    step();
    wvalid = 1'b0;
  endtask

  task automatic send_both(input logic [11:0] a, input logic [31:0] d);
    int n = 0;
    awaddr = a; awvalid = 1'b1; wdata = d; wvalid = 1'b1;
    while (!(awready && wready) && n < 16) begin step(); n++; end
    chk("aw_w_ready_wait", 32'(awready & wready), 32'd1);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  // Mode 0: AW then W, mode 1: W then AW, otherwise together. Returns in the commit cycle.
  task automatic wr_begin(input logic [11:0] a, input logic [31:0] d, input int mode);
    if (mode == 0) begin
      send_aw(a);
      chk("aw_first_awready", 32'(awready), 32'd0);
      chk("aw_first_wready",  32'(wready),  32'd1);
      send_w(d);
    end else if (mode == 1) begin
      send_w(d);
      chk("w_first_wready",  32'(wready),  32'd0);
      chk("w_first_awready", 32'(awready), 32'd1);
      send_aw(a);
    end else begin
      send_both(a, d);
    end
    chk("commit_awready", 32'(awready), 32'd0);
    chk("commit_wready",  32'(wready),  32'd0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input int mode);
    wr_begin(a, d, mode);
    step();
    chk("post_commit_awready", 32'(awready), 32'd1);
    chk("post_commit_wready",  32'(wready),  32'd1);
  endtask

  task automatic rd_issue(input logic [11:0] a);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 16) begin step(); n++; end
    chk("arready_wait", 32'(arready), 32'd1);
    step();
    arvalid = 1'b0;
  endtask

  // n0 = cycles already elapsed since the AR handshake cycle.
  task automatic rd_finish(input string tag, input logic [31:0] exp, input int n0,
                           input int lat, input int hold, input logic done_pulse);
    int n = n0;
    while (!rvalid && n < 12) begin step(); n++; end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_data"}, rdata, exp);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_rvalid"}, 32'(rvalid), 32'd1);
      chk({tag, "_hold_rdata"}, rdata, exp);
    end
    rready = 1'b1; ap_done_in = done_pulse;
    step();
    rready = 1'b0; ap_done_in = 1'b0;
    chk({tag, "_rvalid_clr"}, 32'(rvalid), 32'd0);
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    rd_issue(a);
    rd_finish(tag, exp, 1, 3, 0, 1'b0);
  endtask

  initial begin
    axis_rst = 1'b1;
    awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0;
    arvalid = 1'b0; araddr = '0; rready = 1'b0;
    ap_done_in = 1'b0; core_tap_EN = 1'b0; core_tap_A = '0;
    repeat (3) step();

    // Reset state
    chk("rst_awready",  32'(awready),  32'd1);
    chk("rst_wready",   32'(wready),   32'd1);
    chk("rst_arready",  32'(arready),  32'd1);
    chk("rst_rvalid",   32'(rvalid),   32'd0);
    chk("rst_rdata",    rdata,         32'd0);
    chk("rst_tap_EN",   32'(tap_EN),   32'd0);
    chk("rst_tap_WE",   32'(tap_WE),   32'd0);
    chk("rst_tap_A",    32'(tap_A),    32'd0);
    chk("rst_tap_Di",   tap_Di,        32'd0);
    chk("rst_ap_start", 32'(ap_start), 32'd0);
    chk("rst_len",      data_length,   32'd0);
    chk("rst_taps",     tap_num,       32'd0);
    axis_rst = 1'b0;
    step();

    // Length / tap count under all three write orders
    wr(12'h010, 32'd400, 0);
    wr(12'h014, 32'd20,  0);
    chk("len_aw_first",  data_length, 32'd400);
    chk("taps_aw_first", tap_num,     32'd20);
    wr(12'h010, 32'd800, 1);
    wr(12'h014, 32'd40,  1);
    chk("len_w_first",  data_length, 32'd800);
    chk("taps_w_first", tap_num,     32'd40);
    wr(12'h010, 32'd400, 2);
    wr(12'h014, 32'd20,  2);
    chk("len_same", data_length, 32'd400);
    chk("taps_same", tap_num,    32'd20);
    rd("rd_len",  12'h010, 32'd400);
    rd("rd_taps", 12'h014, 32'd20);
    rd("rd_ctrl_idle", 12'h000, 32'h4);
    rd("rd_unmapped", 12'h020, 32'h0);

    // Coefficients 0..19, read back; first read holds rready low for 5 cycles
    for (int k = 0; k < 20; k++)
      wr(12'(32'h80 + 4 * k), 32'hC0DE_0000 + 32'(k), k % 3);
    for (int k = 0; k < 20; k++) begin
      rd_issue(12'(32'h80 + 4 * k));
      rd_finish("coef", 32'hC0DE_0000 + 32'(k), 1, 3, (k == 0) ? 5 : 0, 1'b0);
    end

    // Write commit to 0x90 collides with tap read of 0x88
    araddr = 12'h088; arvalid = 1'b1;
    awaddr = 12'h090; awvalid = 1'b1; wdata = 32'hABCD_1234; wvalid = 1'b1;
    step();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    chk("coll_wr_WE", 32'(tap_WE), 32'hF);
    chk("coll_wr_A",  32'(tap_A),  32'h010);
    chk("coll_wr_Di", tap_Di,      32'hABCD_1234);
    step();
    chk("coll_rd_EN", 32'(tap_EN), 32'd1);
    chk("coll_rd_WE", 32'(tap_WE), 32'd0);
    chk("coll_rd_A",  32'(tap_A),  32'h008);
    rd_finish("coll_rd", 32'hC0DE_0002, 2, 4, 0, 1'b0);
    rd("coll_wr_back", 12'h090, 32'hABCD_1234);

    // Start: one-cycle pulse, then busy
    wr(12'h000, 32'h1, 2);
    chk("start_pulse_hi", 32'(ap_start), 32'd1);
    step();
    chk("start_pulse_lo", 32'(ap_start), 32'd0);
    rd("rd_ctrl_busy", 12'h000, 32'h0);
    wr(12'h000, 32'h1, 2);
    chk("restart_busy_a", 32'(ap_start), 32'd0);
    step();
    chk("restart_busy_b", 32'(ap_start), 32'd0);

    // Busy: core owns the tap port, writes dropped, tap reads give all-ones
    core_tap_EN = 1'b1; core_tap_A = 12'h03C;
    wr_begin(12'h080, 32'd7, 2);
    chk("busy_wr_WE", 32'(tap_WE), 32'd0);
    chk("busy_wr_EN", 32'(tap_EN), 32'd1);
    chk("busy_wr_A",  32'(tap_A),  32'h03C);
    step();
    wr(12'h010, 32'd999, 2);
    chk("busy_len_drop", data_length, 32'd400);
    rd("busy_rd_tap", 12'h084, 32'hFFFF_FFFF);
    core_tap_EN = 1'b0; core_tap_A = '0;

    // Completion: done read once, then cleared
    ap_done_in = 1'b1;
    step();
    ap_done_in = 1'b0;
    rd("rd_ctrl_done", 12'h000, 32'h6);
    rd("rd_ctrl_reread", 12'h000, 32'h4);
    rd("coef0_kept", 12'h080, 32'hC0DE_0000);

    // Done pulse coincident with the 0x00 read handshake: set wins
    wr(12'h000, 32'h1, 0);
    chk("start2_pulse", 32'(ap_start), 32'd1);
    rd_issue(12'h000);
    rd_finish("rd_ctrl_coinc", 32'h0, 1, 3, 0, 1'b1);
    rd("rd_ctrl_after_coinc", 12'h000, 32'h6);

    // Reset mid-read with a pending AW: everything discarded
    send_aw(12'h014);
    rd_issue(12'h080);
    axis_rst = 1'b1;
    step();
    axis_rst = 1'b0;
    chk("mid_rst_rvalid",  32'(rvalid),  32'd0);
    chk("mid_rst_arready", 32'(arready), 32'd1);
    chk("mid_rst_awready", 32'(awready), 32'd1);
    chk("mid_rst_wready",  32'(wready),  32'd1);
    chk("mid_rst_len",     data_length,  32'd0);
    step();
    chk("post_rst_rvalid", 32'(rvalid), 32'd0);
    send_w(32'd5);
    step();
    chk("post_rst_w_only_wready",  32'(wready),  32'd0);
    chk("post_rst_w_only_awready", 32'(awready), 32'd1);
    chk("post_rst_taps", tap_num, 32'd0);
    send_aw(12'h014);
    step();
    chk("post_rst_taps_commit", tap_num, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
